// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: EX-stage forwarding selects for both ALU operands, EX/MEM over MEM/WB
module fwd_unit
    import pipe_pkg::*;
(
    input  logic       exmem_regwrite_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       memwb_regwrite_i,
    input  logic [4:0] memwb_rd_i,
    input  logic [4:0] src_a_i,
    input  logic [4:0] src_b_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);
    logic exmem_ok, memwb_ok;
    assign exmem_ok = exmem_regwrite_i && exmem_rd_i != 5'd0;
    assign memwb_ok = memwb_regwrite_i && memwb_rd_i != 5'd0;
    // youngest producer wins; register 0 is never forwarded
    always_comb begin
        fwd_a_o = (exmem_ok && exmem_rd_i == src_a_i) ? FWD_EXMEM :
                  (memwb_ok && memwb_rd_i == src_a_i) ? FWD_MEMWB : FWD_RF;
        fwd_b_o = (exmem_ok && exmem_rd_i == src_b_i) ? FWD_EXMEM :
                  (memwb_ok && memwb_rd_i == src_b_i) ? FWD_MEMWB : FWD_RF;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencing and forwarding for a 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             idex_memread,
    input  logic [1:0]       exmem_wb,
    input  logic [1:0]       exmem_m,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic [4:0]        en;
    logic              ifid_fl, idex_fl, stall_inc, flush_inc, mem_busy, load_use;
    logic [1:0]        fa, fb;
    logic              unused_memtoreg;

    assign unused_memtoreg = exmem_wb[MEMTOREG];

    fwd_unit u_fwd (
        .exmem_regwrite_i(exmem_wb[REGWRITE]),
        .exmem_rd_i      (exmem_rd),
        .memwb_regwrite_i(memwb_regwrite),
        .memwb_rd_i      (memwb_rd),
        .src_a_i         (idex_rs),
        .src_b_i         (idex_rt),
        .fwd_a_o         (fa),
        .fwd_b_o         (fb)
    );

    assign mem_busy = (exmem_m != 2'b00) && !dmem_ready;
    assign load_use = idex_memread && idex_rt != 5'd0 && (idex_rt == id_rs || idex_rt == id_rt);

    // next state and control outputs; a completing memory access falls through to the RUN priorities
    always_comb begin
        en        = 5'b11111;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        if (state_q == RUN && mem_busy) begin
            en        = 5'b00000;
            stall_inc = 1'b1;
            state_d   = MEM_WAIT;
        end else if (state_q == MEM_WAIT && !dmem_ready) begin
            en        = 5'b00000;
            stall_inc = 1'b1;
            wait_d    = (wait_q == TMO) ? wait_q : wait_q + 1'b1;
            err_d     = err_q || wait_d == TMO;
        end else begin
            state_d = RUN;
            wait_d  = '0;
            if (branch_taken) begin
                ifid_fl   = 1'b1;
                idex_fl   = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                en        = 5'b00111;
                idex_fl   = 1'b1;
                stall_inc = 1'b1;
            end
        end
        stall_d = (stall_inc && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_inc && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
    end

    // state, timeout tracking and saturating perf counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = rst ? 5'b00000 : en;
    assign ifid_flush = !rst && ifid_fl;
    assign idex_flush = !rst && idex_fl;
    assign forward_a  = rst ? FWD_RF : fa;
    assign forward_b  = rst ? FWD_RF : fb;
    assign mem_err    = err_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic idex_memread, memwb_regwrite, branch_taken, dmem_ready;
    logic [1:0] exmem_wb, exmem_m, forward_a, forward_b;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0, n_err = 0;
    bit m_frozen, m_err;
    int m_wait, m_stall, m_flush;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_wb(exmem_wb), .exmem_m(exmem_m), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .branch_taken(branch_taken),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .forward_a(forward_a), .forward_b(forward_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (exmem_wb[1] && exmem_rd != 0 && exmem_rd == src) return 2'b10;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic clr_in();
        {id_rs, id_rt, idex_rs, idex_rt, exmem_rd, memwb_rd} = '0;
        {idex_memread, memwb_regwrite, branch_taken} = '0;
        exmem_wb = 2'b00;
        exmem_m = 2'b00;
        dmem_ready = 1'b1;
    endtask

    task automatic model_reset();
        m_frozen = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endtask

    // one pipeline cycle with inputs already applied: check outputs, advance model, check registers
    task automatic tick();
        logic [4:0] e_en;
        logic e_ifl, e_idl;
        bit busy, lu, frz;
        #1;
        busy = (exmem_m != 2'b00) && !dmem_ready;
        lu = idex_memread && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt);
        frz = m_frozen ? !dmem_ready : busy;
        e_en = 5'h1f; e_ifl = 0; e_idl = 0;
        if (frz) e_en = 5'h00;
        else if (branch_taken) begin e_ifl = 1; e_idl = 1; end
        else if (lu) begin e_en = 5'b00111; e_idl = 1; end
        chk("enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e_en});
        chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_ifl});
        chk("idex_flush", {31'd0, idex_flush}, {31'd0, e_idl});
        chk("forward_a", {30'd0, forward_a}, {30'd0, ref_fwd(idex_rs)});
        chk("forward_b", {30'd0, forward_b}, {30'd0, ref_fwd(idex_rt)});
        if (frz) begin
            m_stall = sat(m_stall + 1);
            if (m_frozen) begin
                m_wait++;
                if (m_wait >= TMO) m_err = 1;
            end
            m_frozen = 1;
        end else begin
            m_frozen = 0;
            m_wait = 0;
            if (branch_taken) m_flush = sat(m_flush + 1);
            else if (lu) m_stall = sat(m_stall + 1);
        end
        @(posedge clk);
        #1;
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
        chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exmem_wb = 2'b10; exmem_rd = 5'd3; idex_rs = 5'd3; idex_rt = 5'd3;
        branch_taken = 1'b1;
        #1;
        chk("rst_enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
        chk("rst_flush", {30'd0, ifid_flush, idex_flush}, 0);
        chk("rst_fwd", {28'd0, forward_a, forward_b}, 0);
        @(posedge clk);
        #1;
        chk("rst_cnt", {24'd0, stall_cnt, flush_cnt}, 0);
        chk("rst_err", {31'd0, mem_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        clr_in();
        model_reset();
    endtask

    initial begin
        clr_in();
        model_reset();
        do_reset();
        // load-use stall
        idex_memread = 1; idex_rt = 5'd2; id_rs = 5'd2;
        tick();
        chk("lu_stall", {28'd0, stall_cnt}, 1);
        // forwarding priority and rd==0 exclusion
        @(negedge clk);
        clr_in();
        exmem_wb = 2'b10; exmem_rd = 5'd5; memwb_regwrite = 1; memwb_rd = 5'd5; idex_rs = 5'd5;
        tick();
        chk("fwd_exmem", {30'd0, forward_a}, 2'b10);
        @(negedge clk);
        exmem_rd = 5'd0;
        tick();
        chk("fwd_memwb", {30'd0, forward_a}, 2'b01);
        // memory freeze for three cycles then release
        do_reset();
        exmem_m = 2'b10; dmem_ready = 0;
        repeat (3) tick();
        @(negedge clk);
        dmem_ready = 1;
        tick();
        chk("freeze_stall", {28'd0, stall_cnt}, 3);
        // branch beats load-use
        do_reset();
        branch_taken = 1; idex_memread = 1; idex_rt = 5'd2; id_rs = 5'd2;
        tick();
        chk("br_flush", {28'd0, flush_cnt}, 1);
        chk("br_stall", {28'd0, stall_cnt}, 0);
        // timeout after TMO cycles in MEM_WAIT, then async reset mid-wait
        do_reset();
        exmem_m = 2'b01; dmem_ready = 0;
        repeat (TMO) tick();
        chk("tmo_not_yet", {31'd0, mem_err}, 0);
        tick();
        chk("tmo_err", {31'd0, mem_err}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_err", {31'd0, mem_err}, 0);
        chk("async_cnt", {28'd0, stall_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        clr_in();
        model_reset();
        tick();
        chk("post_rst_run", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'h1f);
        // saturation of both counters
        do_reset();
        idex_memread = 1; idex_rt = 5'd7; id_rt = 5'd7;
        repeat (CMAX + 2) tick();
        chk("stall_sat", {28'd0, stall_cnt}, CMAX);
        @(negedge clk);
        branch_taken = 1;
        repeat (CMAX + 2) tick();
        chk("flush_sat", {28'd0, flush_cnt}, CMAX);
        // randomized segments
        for (int s = 0; s < 10; s++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                id_rs = 5'($urandom_range(0, 3));
                id_rt = 5'($urandom_range(0, 3));
                idex_rs = 5'($urandom_range(0, 3));
                idex_rt = 5'($urandom_range(0, 3));
                exmem_rd = 5'($urandom_range(0, 3));
                memwb_rd = 5'($urandom_range(0, 3));
                idex_memread = 1'($urandom_range(0, 1));
                memwb_regwrite = 1'($urandom_range(0, 1));
                exmem_wb = 2'($urandom_range(0, 3));
                exmem_m = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                dmem_ready = 1'($urandom_range(0, 1));
                branch_taken = ($urandom_range(0, 4) == 0);
                tick();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
